// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one 8-entry register file between two requesters.
// A granted request is latched into a command register, drives the regfile
// for one cycle, and its read data comes back one cycle later with a Resp pulse.
module regfile_arbiter #(
   parameter int DATA_W = 16,
   parameter int RR_EN  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              req0,
   input  logic              req1,
   output logic              gnt0,
   output logic              gnt1,
   input  logic [2:0]        a_sel0,
   input  logic [2:0]        a_sel1,
   input  logic [2:0]        b_sel0,
   input  logic [2:0]        b_sel1,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic [2:0]        wr_addr0,
   input  logic [2:0]        wr_addr1,
   input  logic [2:0]        fun_sel0,
   input  logic [2:0]        fun_sel1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic              resp0,
   output logic              resp1,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] rf_i,
   output logic [2:0]        rf_out_a_sel,
   output logic [2:0]        rf_out_b_sel,
   output logic [2:0]        rf_fun_sel,
   output logic [3:0]        rf_reg_sel,
   output logic [3:0]        rf_scr_sel,
   input  logic [DATA_W-1:0] rf_out_a,
   input  logic [DATA_W-1:0] rf_out_b
);

   // Side that wins a tie when round-robin is enabled (0 = requester 0).
   logic              rr_ptr;
   logic              accept;

   // Command register: the accepted transaction plus who asked for it.
   logic              cmd_valid;
   logic              cmd_owner;
   logic              cmd_wr_en;
   logic [2:0]        cmd_a_sel;
   logic [2:0]        cmd_b_sel;
   logic [2:0]        cmd_wr_addr;
   logic [2:0]        cmd_fun_sel;
   logic [DATA_W-1:0] cmd_wr_data;

   // Grant logic: nothing while held or in reset, otherwise the lone requester or the pointer side.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && !hold) begin
         if (req0 && req1) begin
            if ((RR_EN != 0) && rr_ptr) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else if (req0) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign accept = (req0 && gnt0) || (req1 && gnt1);

   // Pointer moves to the requester that just lost, so it wins the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (accept && (RR_EN != 0)) begin
         rr_ptr <= gnt0;
      end
   end

   // Latch the winner's fields at acceptance; fields hold their last value while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid   <= 1'b0;
         cmd_owner   <= 1'b0;
         cmd_wr_en   <= 1'b0;
         cmd_a_sel   <= '0;
         cmd_b_sel   <= '0;
         cmd_wr_addr <= '0;
         cmd_fun_sel <= '0;
         cmd_wr_data <= '0;
      end else begin
         cmd_valid <= accept;
         if (accept) begin
            cmd_owner   <= gnt1;
            cmd_wr_en   <= gnt1 ? wr_en1   : wr_en0;
            cmd_a_sel   <= gnt1 ? a_sel1   : a_sel0;
            cmd_b_sel   <= gnt1 ? b_sel1   : b_sel0;
            cmd_wr_addr <= gnt1 ? wr_addr1 : wr_addr0;
            cmd_fun_sel <= gnt1 ? fun_sel1 : fun_sel0;
            cmd_wr_data <= gnt1 ? wr_data1 : wr_data0;
         end
      end
   end

   assign rf_i         = cmd_wr_data;
   assign rf_out_a_sel = cmd_a_sel;
   assign rf_out_b_sel = cmd_b_sel;
   assign rf_fun_sel   = cmd_fun_sel;

   // Active-low one-hot enable for the target register, only while a write command is live.
   always_comb begin
      rf_reg_sel = 4'b1111;
      rf_scr_sel = 4'b1111;
      if (cmd_valid && cmd_wr_en) begin
         if (!cmd_wr_addr[2]) begin
            rf_reg_sel[2'd3 - cmd_wr_addr[1:0]] = 1'b0;
         end else begin
            rf_scr_sel[2'd3 - cmd_wr_addr[1:0]] = 1'b0;
         end
      end
   end

   // Capture read data at the same edge the regfile writes, so it reflects pre-write contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0     <= 1'b0;
         resp1     <= 1'b0;
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         resp0 <= cmd_valid && !cmd_owner;
         resp1 <= cmd_valid && cmd_owner;
         if (cmd_valid) begin
            rd_data_a <= rf_out_a;
            rd_data_b <= rf_out_b;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a small behavioural regfile model.
// A second instance with RR_EN=0 shares the stimulus to check fixed priority.
module tb_regfile_arbiter;

   localparam int DW = 16;
   localparam logic [2:0] FUN_LOAD = 3'd2;

   logic          clk;
   logic          rst_n;
   logic          hold;
   logic          req0, req1;
   logic          gnt0, gnt1;
   logic [2:0]    a_sel0, a_sel1, b_sel0, b_sel1;
   logic          wr_en0, wr_en1;
   logic [2:0]    wr_addr0, wr_addr1, fun_sel0, fun_sel1;
   logic [DW-1:0] wr_data0, wr_data1;
   logic          resp0, resp1;
   logic [DW-1:0] rd_data_a, rd_data_b, rf_i;
   logic [2:0]    rf_out_a_sel, rf_out_b_sel, rf_fun_sel;
   logic [3:0]    rf_reg_sel, rf_scr_sel;
   logic [DW-1:0] rf_out_a, rf_out_b;

   logic          gnt0_fp, gnt1_fp, resp0_fp, resp1_fp;
   logic [DW-1:0] rd_a_fp, rd_b_fp, rf_i_fp;
   logic [2:0]    a_sel_fp, b_sel_fp, fun_fp;
   logic [3:0]    reg_sel_fp, scr_sel_fp;

   logic [DW-1:0] regs [8];
   logic          pre_en;
   logic [2:0]    pre_idx;
   logic [DW-1:0] pre_val;

   int total = 0;
   int bad   = 0;

   regfile_arbiter #(.DATA_W(DW), .RR_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .req0(req0), .req1(req1),
      .gnt0(gnt0), .gnt1(gnt1), .a_sel0(a_sel0), .a_sel1(a_sel1),
      .b_sel0(b_sel0), .b_sel1(b_sel1), .wr_en0(wr_en0), .wr_en1(wr_en1),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .fun_sel0(fun_sel0), .fun_sel1(fun_sel1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .resp0(resp0), .resp1(resp1),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rf_i(rf_i),
      .rf_out_a_sel(rf_out_a_sel), .rf_out_b_sel(rf_out_b_sel), .rf_fun_sel(rf_fun_sel),
      .rf_reg_sel(rf_reg_sel), .rf_scr_sel(rf_scr_sel), .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
   );

   regfile_arbiter #(.DATA_W(DW), .RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .hold(hold), .req0(req0), .req1(req1),
      .gnt0(gnt0_fp), .gnt1(gnt1_fp), .a_sel0(a_sel0), .a_sel1(a_sel1),
      .b_sel0(b_sel0), .b_sel1(b_sel1), .wr_en0(wr_en0), .wr_en1(wr_en1),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .fun_sel0(fun_sel0), .fun_sel1(fun_sel1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .resp0(resp0_fp), .resp1(resp1_fp),
      .rd_data_a(rd_a_fp), .rd_data_b(rd_b_fp), .rf_i(rf_i_fp),
      .rf_out_a_sel(a_sel_fp), .rf_out_b_sel(b_sel_fp), .rf_fun_sel(fun_fp),
      .rf_reg_sel(reg_sel_fp), .rf_scr_sel(scr_sel_fp), .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regfile model: index 0-3 = R1-R4, 4-7 = S1-S4; load when enabled with FUN_LOAD.
   always @(posedge clk) begin
      if (pre_en) begin
         regs[pre_idx] <= pre_val;
      end else if (rf_fun_sel == FUN_LOAD) begin
         for (int i = 0; i < 4; i++) begin
            if (!rf_reg_sel[3-i]) regs[i] <= rf_i;
            if (!rf_scr_sel[3-i]) regs[i+4] <= rf_i;
         end
      end
   end

   assign rf_out_a = regs[rf_out_a_sel];
   assign rf_out_b = regs[rf_out_b_sel];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preload_reg(input logic [2:0] idx, input logic [DW-1:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      tick();
      pre_en  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req0 = 1'b1;
      #1;
      total++; if (gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL rst_gnt0 got=%0h exp=0", gnt0); end
      total++; if (rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL rst_reg_sel got=%b exp=1111", rf_reg_sel); end
      total++; if (rf_scr_sel !== 4'b1111) begin bad++; $display("[TB] FAIL rst_scr_sel got=%b exp=1111", rf_scr_sel); end
      total++; if (resp0 !== 1'b0 || resp1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp got=%b%b exp=00", resp0, resp1); end
      total++; if (rd_data_a !== 16'h0 || rf_i !== 16'h0) begin bad++; $display("[TB] FAIL rst_data got=%h/%h exp=0/0", rd_data_a, rf_i); end
      total++; if (rf_out_a_sel !== 3'd0 || rf_fun_sel !== 3'd0) begin bad++; $display("[TB] FAIL rst_sel got=%0d/%0d exp=0/0", rf_out_a_sel, rf_fun_sel); end
      req0 = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      req0 = 1'b1; wr_en0 = 1'b1; wr_addr0 = 3'd2; fun_sel0 = FUN_LOAD;
      wr_data0 = 16'hBEEF; a_sel0 = 3'd2; b_sel0 = 3'd6;
      #1;
      total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL t1_gnt got=%b%b exp=10", gnt0, gnt1); end
      total++; if (rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t1_a_reg_sel got=%b exp=1111", rf_reg_sel); end
      tick();
      req0 = 1'b0;
      total++; if (rf_reg_sel !== 4'b1101) begin bad++; $display("[TB] FAIL t1_b_reg_sel got=%b exp=1101", rf_reg_sel); end
      total++; if (rf_scr_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t1_b_scr_sel got=%b exp=1111", rf_scr_sel); end
      total++; if (rf_i !== 16'hBEEF || rf_fun_sel !== FUN_LOAD) begin bad++; $display("[TB] FAIL t1_b_data got=%h/%0d exp=beef/2", rf_i, rf_fun_sel); end
      total++; if (resp0 !== 1'b0) begin bad++; $display("[TB] FAIL t1_b_resp0 got=%b exp=0", resp0); end
      tick();
      total++; if (resp0 !== 1'b1 || resp1 !== 1'b0) begin bad++; $display("[TB] FAIL t1_c_resp got=%b%b exp=10", resp0, resp1); end
      total++; if (rd_data_a !== 16'h1002 || rd_data_b !== 16'h1006) begin bad++; $display("[TB] FAIL t1_c_rd got=%h/%h exp=1002/1006", rd_data_a, rd_data_b); end
      total++; if (rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t1_c_reg_sel got=%b exp=1111", rf_reg_sel); end
      tick();
      total++; if (resp0 !== 1'b0) begin bad++; $display("[TB] FAIL t1_d_resp0 got=%b exp=0", resp0); end
      wr_en0 = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      req0 = 1'b1; req1 = 1'b1; a_sel0 = 3'd2; a_sel1 = 3'd2; wr_en0 = 1'b0; wr_en1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
         #1;
         if (k < 4) begin
            total++; if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin bad++; $display("[TB] FAIL t2_gnt k=%0d got=%b%b exp=%b%b", k, gnt0, gnt1, (k % 2 == 0), (k % 2 == 1)); end
            total++; if (gnt0_fp !== 1'b1 || gnt1_fp !== 1'b0) begin bad++; $display("[TB] FAIL t2_fp_gnt k=%0d got=%b%b exp=10", k, gnt0_fp, gnt1_fp); end
         end
         total++; if (resp0 !== (k >= 2 && k % 2 == 0) || resp1 !== (k >= 2 && k % 2 == 1)) begin bad++; $display("[TB] FAIL t2_resp k=%0d got=%b%b", k, resp0, resp1); end
         if (k >= 2) begin
            total++; if (rd_data_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL t2_rd k=%0d got=%h exp=beef", k, rd_data_a); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      req1 = 1'b1; wr_en1 = 1'b1; wr_addr1 = 3'd7; fun_sel1 = FUN_LOAD; wr_data1 = 16'h1234;
      a_sel1 = 3'd7; b_sel1 = 3'd0;
      #1;
      total++; if (gnt1 !== 1'b1) begin bad++; $display("[TB] FAIL t3_gnt1 got=%b exp=1", gnt1); end
      tick();
      req1 = 1'b0; wr_en1 = 1'b0;
      req0 = 1'b1; a_sel0 = 3'd7; b_sel0 = 3'd3; wr_en0 = 1'b0;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL t3_gnt0 got=%b exp=1", gnt0); end
      total++; if (rf_scr_sel !== 4'b1110 || rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t3_sel got=%b/%b exp=1110/1111", rf_scr_sel, rf_reg_sel); end
      tick();
      req0 = 1'b0;
      total++; if (resp1 !== 1'b1 || resp0 !== 1'b0) begin bad++; $display("[TB] FAIL t3_resp1 got=%b%b exp=01", resp0, resp1); end
      total++; if (rd_data_a !== 16'h1007) begin bad++; $display("[TB] FAIL t3_old_s4 got=%h exp=1007", rd_data_a); end
      total++; if (rf_scr_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t3_scr_idle got=%b exp=1111", rf_scr_sel); end
      tick();
      total++; if (resp0 !== 1'b1 || resp1 !== 1'b0) begin bad++; $display("[TB] FAIL t3_resp0 got=%b%b exp=10", resp0, resp1); end
      total++; if (rd_data_a !== 16'h1234 || rd_data_b !== 16'h1003) begin bad++; $display("[TB] FAIL t3_rd got=%h/%h exp=1234/1003", rd_data_a, rd_data_b); end
   endtask

   task automatic test_same_addr();
      preload_reg(3'd0, 16'h0005);
      req0 = 1'b1; wr_en0 = 1'b1; wr_addr0 = 3'd0; a_sel0 = 3'd0; fun_sel0 = FUN_LOAD; wr_data0 = 16'h00AA;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL t4_gnt0 got=%b exp=1", gnt0); end
      tick();
      req0 = 1'b0; wr_en0 = 1'b0;
      total++; if (rf_reg_sel !== 4'b0111) begin bad++; $display("[TB] FAIL t4_reg_sel got=%b exp=0111", rf_reg_sel); end
      tick();
      total++; if (resp0 !== 1'b1 || rd_data_a !== 16'h0005) begin bad++; $display("[TB] FAIL t4_old got=%b/%h exp=1/0005", resp0, rd_data_a); end
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick();
      total++; if (resp0 !== 1'b1 || rd_data_a !== 16'h00AA) begin bad++; $display("[TB] FAIL t4_new got=%b/%h exp=1/00aa", resp0, rd_data_a); end
   endtask

   task automatic test_hold();
      req0 = 1'b1; wr_en0 = 1'b1; wr_addr0 = 3'd4; fun_sel0 = FUN_LOAD; wr_data0 = 16'h55AA; a_sel0 = 3'd4;
      #1;
      total++; if (gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL t5_pre_gnt got=%b exp=1", gnt0); end
      tick();
      wr_en0 = 1'b0; hold = 1'b1; req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL t5_gnt k=%0d got=%b%b exp=00", k, gnt0, gnt1); end
         if (k == 0) begin
            total++; if (rf_scr_sel !== 4'b0111) begin bad++; $display("[TB] FAIL t5_inflight got=%b exp=0111", rf_scr_sel); end
         end else begin
            total++; if (rf_scr_sel !== 4'b1111 || rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t5_idle k=%0d got=%b/%b exp=1111/1111", k, rf_scr_sel, rf_reg_sel); end
         end
         if (k == 1) begin
            total++; if (resp0 !== 1'b1 || rd_data_a !== 16'h1004) begin bad++; $display("[TB] FAIL t5_resp got=%b/%h exp=1/1004", resp0, rd_data_a); end
         end
         if (k == 2) begin
            total++; if (resp0 !== 1'b0 || resp1 !== 1'b0) begin bad++; $display("[TB] FAIL t5_noresp got=%b%b exp=00", resp0, resp1); end
         end
         tick();
      end
      hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_inflight();
      req0 = 1'b1; wr_en0 = 1'b1; wr_addr0 = 3'd3; fun_sel0 = FUN_LOAD; wr_data0 = 16'hDEAD;
      tick();
      req0 = 1'b0; wr_en0 = 1'b0;
      total++; if (rf_reg_sel !== 4'b1110) begin bad++; $display("[TB] FAIL t6_b_sel got=%b exp=1110", rf_reg_sel); end
      rst_n = 1'b0;
      #1;
      total++; if (rf_reg_sel !== 4'b1111) begin bad++; $display("[TB] FAIL t6_rst_sel got=%b exp=1111", rf_reg_sel); end
      tick();
      rst_n = 1'b1;
      total++; if (regs[3] !== 16'h1003) begin bad++; $display("[TB] FAIL t6_r4 got=%h exp=1003", regs[3]); end
      total++; if (resp0 !== 1'b0 || rd_data_a !== 16'h0) begin bad++; $display("[TB] FAIL t6_c got=%b/%h exp=0/0000", resp0, rd_data_a); end
      tick();
      total++; if (resp0 !== 1'b0) begin bad++; $display("[TB] FAIL t6_late_resp got=%b exp=0", resp0); end
      req0 = 1'b1; req1 = 1'b1;
      #1;
      total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL t6_ptr got=%b%b exp=10", gnt0, gnt1); end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a_sel0 = '0; a_sel1 = '0; b_sel0 = '0; b_sel1 = '0;
      wr_en0 = 1'b0; wr_en1 = 1'b0; wr_addr0 = '0; wr_addr1 = '0;
      fun_sel0 = '0; fun_sel1 = '0; wr_data0 = '0; wr_data1 = '0;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         preload_reg(3'(i), 16'h1000 + 16'(i));
      end
      test_reset();
      test_single_write();
      test_round_robin();
      test_back_to_back();
      test_same_addr();
      test_hold();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one 8-entry register file (R1–R4 general, S1–S4 scratch; active-low one-hot write selects, 3-bit FunSel, two combinational read ports) between two requesters, e.g. fetch/decode and ALU control.
- Each accepted request is one regfile transaction: two reads plus an optional write or register function.
- The block arbitrates round-robin, registers the winning command, drives the regfile for one cycle, and returns the read data one cycle later.

Parameters:
- DATA_W, 16, regfile data width.
- RR_EN, 1. 1 selects round-robin arbitration; 0 selects fixed priority, where requester 0 always wins.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Hold  in  1  1 blocks new grants; an in-flight command still completes.
- Req0/Req1  in  1  request valid; held with its fields stable until Gnt.
- Gnt0/Gnt1  out  1  combinational grant; the transfer occurs on a rising edge where Req&Gnt.
- ASel0/ASel1  in  3  read port A select: 0–3 = R1–R4, 4–7 = S1–S4.
- BSel0/BSel1  in  3  read port B select, same encoding as ASel.
- WrEn0/WrEn1  in  1  1 enables the target register for this transaction.
- WrAddr0/WrAddr1  in  3  target register, same encoding as ASel.
- FunSel0/FunSel1  in  3  register function, passed unchanged to the regfile.
- WrData0/WrData1  in  DATA_W  regfile input data.
- Resp0/Resp1  out  1  one-cycle pulse: RdDataA/B belong to this requester.
- RdDataA, RdDataB  out  DATA_W  captured read data.
- RF_I  out  DATA_W  to regfile I.
- RF_OutASel, RF_OutBSel  out  3  to regfile.
- RF_FunSel  out  3  to regfile.
- RF_RegSel, RF_ScrSel  out  4  active-low enables; MSB = R1/S1, LSB = R4/S4.
- RF_OutA, RF_OutB  in  DATA_W  from regfile.

Behaviour:

Reset (Reset=0, asynchronous):
- RF_RegSel = RF_ScrSel = 4'b1111.
- RF_FunSel = 0, RF_I = 0, RF_OutASel = RF_OutBSel = 0.
- Resp0 = Resp1 = 0, RdDataA = RdDataB = 0.
- Priority pointer = 0, command-valid flag = 0.
- An in-flight command is discarded with no regfile write; its Resp never fires.

Arbitration (combinational):
- With Hold=1 or Reset=0, Gnt0 = Gnt1 = 0.
- Otherwise, if only one requester is asserting Req, it is granted.
- If both are asserting Req, the pointer side is granted (requester 0 when RR_EN=0).
- At most one Gnt is high at a time.
- A Gnt is never given without the matching Req.

Pointer update:
- After each accepted transfer with RR_EN=1, the pointer moves to the non-granted requester.
- The pointer is unchanged when no transfer occurs.

Pipeline and latency:
- Cycle A: Req&Gnt. The command (fields plus owner id) is latched at the end of A.
- Cycle B: all RF_* outputs are driven from the command register.
  - RF_OutASel/BSel come from ASel/BSel.
  - RF_I comes from WrData; RF_FunSel comes from FunSel.
  - With WrEn=1, exactly one enable bit is cleared:
    - WrAddr[2]=0 → RF_RegSel bit (3−WrAddr[1:0]) = 0.
    - WrAddr[2]=1 → the same bit of RF_ScrSel = 0.
  - The other enable vector stays 4'b1111.
  - With WrEn=0, both vectors stay 4'b1111.
  - The regfile updates at the end of B. RF_OutA/RF_OutB are captured into RdDataA/B at the same edge, so the returned data holds pre-write values.
- Cycle C: Resp<owner>=1 for exactly one cycle; RdDataA/B hold until the next capture.
- Latency from accept to Resp is 2 cycles. Throughput is 1 transaction per cycle.
- Back-to-back commands: a read in cycle B sees the write made by the previous command.

Idle:
- When no command was accepted in A, cycle B drives RF_RegSel = RF_ScrSel = 4'b1111 with no write.
- RdDataA/B are not updated and no Resp fires.
- Select and data outputs keep their last value.

Boundary cases:
- Hold rising while a command is in B/C: that command completes normally.
- A request held across several cycles without Gnt keeps its fields stable; they are resampled only at acceptance.
- A requester re-requesting immediately after its own grant while the other is requesting loses to the other requester (RR_EN=1).
- WrAddr equal to ASel in the same command: RdDataA returns the old value.

Test Plan:
1. Reset, then Req0 with WrEn0=1, WrAddr0=2, FunSel0=load, WrData0=16'hBEEF → Gnt0 in A; RF_RegSel=4'b1101 and RF_ScrSel=4'b1111 in B only; Resp0 in C.
2. Req0 and Req1 held high for 4 cycles, both reading R3 → grants 0,1,0,1; Resp pattern 0,1,0,1 two cycles later; with RR_EN=0 → grants 0,0,0,0.
3. Back-to-back: requester 1 writes S4=16'h1234 (RF_ScrSel=4'b1110), then next cycle requester 0 reads ASel=7 → RdDataA=16'h1234.
4. Single command with WrAddr0=0, ASel0=0, R1 preloaded 16'h0005, write 16'h00AA → RdDataA=16'h0005; a later read returns 16'h00AA.
5. Hold=1 while both request → no Gnt for 3 cycles and enables stay 4'b1111; the command accepted before Hold still yields its Resp.
6. Reset asserted in cycle B of a write to R4 → RF_RegSel forced to 4'b1111 immediately; R4 unchanged; no Resp after release; pointer back to 0.
